// File: rtl/control_unit_if.sv
// Control bus between the hardwired sequencer and the single-bus datapath.
// The master side (sequencer) consumes the IR opcode field and the stop
// request and drives every datapath strobe; the slave side is the datapath.
interface control_unit_if;
    logic [4:0] ir_opcode;
    logic       stop;

    logic       PC_out;
    logic       MDR_out;
    logic       ZLow_out;
    logic       C_out;
    logic       BA_out;
    logic       R_out;

    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       R_in;

    logic       MAR_enable;
    logic       MDR_enable;
    logic       IR_enable;
    logic       Y_enable;
    logic       Z_enable;
    logic       PC_enable;

    logic       IncPC;
    logic       Read;
    logic       RAM_write_enable;

    logic [4:0] opcode;
    logic       run;
    logic [3:0] state;

    modport master (
        input  ir_opcode, stop,
        output PC_out, MDR_out, ZLow_out, C_out, BA_out, R_out,
        output Gra, Grb, Grc, R_in,
        output MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable,
        output IncPC, Read, RAM_write_enable,
        output opcode, run, state
    );

    modport slave (
        output ir_opcode, stop,
        input  PC_out, MDR_out, ZLow_out, C_out, BA_out, R_out,
        input  Gra, Grb, Grc, R_in,
        input  MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable,
        input  IncPC, Read, RAM_write_enable,
        input  opcode, run, state
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired control sequencer: three-cycle fetch (T0-T2) followed by a
// per-opcode execute sequence (T3-T7). Strobes are decoded from the
// registered state so that an asynchronous clear drops them immediately.
module control_unit #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic          clk,
    input  logic          clr,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Memory-access instructions that run all the way to T7.
    function automatic logic f_long(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Instructions that finish in T5.
    function automatic logic f_mid(input logic [4:0] op);
        return (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR)  || (op == OP_ADDI);
    endfunction

    state_t r_state;
    state_t w_end_next;

    // Stop is only honoured at an instruction boundary.
    assign w_end_next = bus.stop ? S_HALT : S_T0;
    assign bus.state  = r_state;

    // State register and sequencing; illegal codes recover to RESET.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_RESET;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= S_T1;
                S_T1:    r_state <= S_T2;
                S_T2:    r_state <= S_T3;
                S_T3: begin
                    if (bus.ir_opcode == OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (f_long(bus.ir_opcode) || f_mid(bus.ir_opcode)) begin
                        r_state <= S_T4;
                    end else begin
                        r_state <= w_end_next;
                    end
                end
                S_T4:    r_state <= S_T5;
                S_T5: begin
                    if (f_long(bus.ir_opcode)) begin
                        r_state <= S_T6;
                    end else begin
                        r_state <= w_end_next;
                    end
                end
                S_T6:    r_state <= S_T7;
                S_T7:    r_state <= w_end_next;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RESET;
            endcase
        end
    end

    // Strobe decode from current state and IR opcode; unlisted strobes stay 0.
    always_comb begin
        bus.PC_out           = 1'b0;
        bus.MDR_out          = 1'b0;
        bus.ZLow_out         = 1'b0;
        bus.C_out            = 1'b0;
        bus.BA_out           = 1'b0;
        bus.R_out            = 1'b0;
        bus.Gra              = 1'b0;
        bus.Grb              = 1'b0;
        bus.Grc              = 1'b0;
        bus.R_in             = 1'b0;
        bus.MAR_enable       = 1'b0;
        bus.MDR_enable       = 1'b0;
        bus.IR_enable        = 1'b0;
        bus.Y_enable         = 1'b0;
        bus.Z_enable         = 1'b0;
        bus.PC_enable        = 1'b0;
        bus.IncPC            = 1'b0;
        bus.Read             = 1'b0;
        bus.RAM_write_enable = 1'b0;
        bus.opcode           = 5'b00000;
        bus.run              = 1'b1;
        case (r_state)
            S_T0: begin
                bus.PC_out     = 1'b1;
                bus.MAR_enable = 1'b1;
                bus.IncPC      = 1'b1;
                bus.PC_enable  = 1'b1;
            end
            S_T1: begin
                bus.Read       = 1'b1;
                bus.MDR_enable = 1'b1;
            end
            S_T2: begin
                bus.MDR_out    = 1'b1;
                bus.IR_enable  = 1'b1;
            end
            S_T3: begin
                case (bus.ir_opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        bus.Grb      = 1'b1;
                        bus.BA_out   = 1'b1;
                        bus.Y_enable = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        bus.Grb      = 1'b1;
                        bus.R_out    = 1'b1;
                        bus.Y_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (bus.ir_opcode)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        bus.C_out    = 1'b1;
                        bus.Z_enable = 1'b1;
                        bus.opcode   = ADD_OP;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        bus.Grc      = 1'b1;
                        bus.R_out    = 1'b1;
                        bus.Z_enable = 1'b1;
                        bus.opcode   = bus.ir_opcode;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (bus.ir_opcode)
                    OP_LD, OP_ST: begin
                        bus.ZLow_out   = 1'b1;
                        bus.MAR_enable = 1'b1;
                    end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        bus.ZLow_out = 1'b1;
                        bus.Gra      = 1'b1;
                        bus.R_in     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (bus.ir_opcode)
                    OP_LD: begin
                        bus.Read       = 1'b1;
                        bus.MDR_enable = 1'b1;
                    end
                    // Read stays low so the MDR captures the register on the bus.
                    OP_ST: begin
                        bus.Gra        = 1'b1;
                        bus.R_out      = 1'b1;
                        bus.MDR_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (bus.ir_opcode)
                    OP_LD: begin
                        bus.MDR_out = 1'b1;
                        bus.Gra     = 1'b1;
                        bus.R_in    = 1'b1;
                    end
                    OP_ST: begin
                        bus.RAM_write_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                bus.run = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the single-bus datapath. It steps through a three-cycle instruction fetch (T0–T2) and a per-opcode execute sequence (T3–T7), driving every datapath strobe and register-select line. It replaces the hand-scripted state sequencing used in datapath benches. It sits beside `Datapath`, reads the IR opcode field, and stops the machine on `halt` or an external stop request.

## Interface
- `ADD_OP`, default 5'b00011: ALU opcode driven for address or immediate computation.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  asynchronous, active-low reset.
- `ir_opcode`  in  5  IR[31:27]; valid from T3 onward.
- `stop`  in  1  external halt request, level-sensitive.
- `PC_out, MDR_out, ZLow_out, C_out, BA_out, R_out`  out  1 each  bus drive selects.
- `Gra, Grb, Grc, R_in`  out  1 each  register-field select and register load.
- `MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable`  out  1 each  register loads.
- `IncPC, Read, RAM_write_enable`  out  1 each  PC increment, memory read, memory write.
- `opcode`  out  5  ALU operation.
- `run`  out  1  high unless halted.
- `state`  out  4  current state code, for debug.

## Operation
- States and codes: RESET=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, T7=8, HALT=9. Codes 10–15 are illegal and go to RESET.
- Outputs are decoded combinationally from the registered `state` and `ir_opcode`.
- Any strobe not listed for a state is 0.
- `opcode` is 0 except in T4.
- Fetch, common to all instructions:
  - T0: PC_out, MAR_enable, IncPC, PC_enable.
  - T1: Read, MDR_enable.
  - T2: MDR_out, IR_enable.
- Instruction opcodes (`ir_opcode`): ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, nop=11010, halt=11011.
- ld:
  - T3: Grb, BA_out, Y_enable.
  - T4: C_out, Z_enable, opcode=ADD_OP.
  - T5: ZLow_out, MAR_enable.
  - T6: Read, MDR_enable.
  - T7: MDR_out, Gra, R_in.
- ldi: T3 and T4 as ld; T5: ZLow_out, Gra, R_in.
- st:
  - T3–T5 as ld.
  - T6: Gra, R_out, MDR_enable; Read=0, so MDR loads from the bus.
  - T7: RAM_write_enable.
- add, sub, and, or:
  - T3: Grb, R_out, Y_enable.
  - T4: Grc, R_out, Z_enable, opcode=ir_opcode.
  - T5: ZLow_out, Gra, R_in.
- addi:
  - T3: Grb, R_out, Y_enable.
  - T4: C_out, Z_enable, opcode=ADD_OP.
  - T5: ZLow_out, Gra, R_in.
- nop and undefined opcodes: T3 only, with no strobes.
- halt: T3 with no strobes, then HALT.
- Last state of each instruction: T7 for ld and st; T5 for ldi, ALU and addi; T3 for nop and undefined opcodes.
- From the last state, go to HALT if `stop`=1 at that edge, otherwise go to T0.
- HALT is terminal: all strobes are 0 and run=0. Only `clr` leaves HALT.

## Timing
- Each state lasts exactly one clk cycle.
- Instruction lengths, fetch included: ld/st 8 cycles; ldi/ALU/addi 6; nop 4.
- While `clr`=0: state=RESET, all strobes 0, opcode=0, run=1.
- The first rising edge after `clr` deasserts moves RESET→T0.
- `clr` asserted mid-instruction forces RESET immediately, without waiting for a clock, and all strobes drop in the same delta.
- `stop` is ignored except at the last state of an instruction, so an instruction is never truncated.
- `stop`=1 at the instruction boundary combined with halt: go to HALT; the two causes are indistinguishable.
- `ir_opcode` may change during T0–T2; it is only decoded in T3 and later states.

## Test plan
- Reset then ld (ir_opcode=00000):
  - state sequence 0,1,2,3,4,5,6,7,8,1.
  - T4 opcode=00011 with C_out=1.
  - T7 MDR_out=Gra=R_in=1.
  - every strobe in RESET is 0.
- st (00010):
  - T6 has R_out=Gra=MDR_enable=1 and Read=0.
  - T7 has RAM_write_enable=1.
  - the next state is T0.
- sub (00100):
  - T4 opcode=00100 with Grc=R_out=Z_enable=1.
  - T5 R_in=1.
  - 6 cycles from T0 to the next T0.
- addi (01100) then ldi (00001):
  - both instructions complete in 6 cycles.
  - T4 opcode=00011 in both.
  - neither asserts Read after T1.
- halt (11011):
  - after T3, state=9 and run=0.
  - state stays 9 for 20 cycles while the bench sweeps ir_opcode.
  - `clr` low for one cycle returns state=0 and run=1.
- stop and reset:
  - `stop` pulsed high during T4 of ld and released before T7: the machine continues to T0.
  - `stop` held high through T7: state=9.
  - `clr` driven low mid-T5: state=0 before the next clk edge.
